alut_age_sched: RTL
===================

ALUT_AGE_SCHED -- requirements
Module: alut_age_sched

Interface
REQ-001 The block SHALL have parameter DW, default 83, giving the table entry width.
REQ-002 The block SHALL have parameter DD, default 256, giving the number of entries swept (1..256).
REQ-003 The block SHALL have port pclk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port p_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port age_start, input, 1 bit: a one-cycle request to begin a sweep.
REQ-006 The block SHALL have port age_stop, input, 1 bit: aborts a sweep in progress.
REQ-007 The block SHALL have port cur_time, input, 32 bits: the current timestamp.
REQ-008 The block SHALL have port age_limit, input, 32 bits: the maximum permitted entry age.
REQ-009 The block SHALL have port mem_addr_add, input, 8 bits: snooped address of the add/lookup port.
REQ-010 The block SHALL have port mem_write_add, input, 1 bit: snooped write strobe of the add/lookup port.
REQ-011 The block SHALL have port mem_read_data_age, input, DW bits: memory read data, valid the cycle after a read is issued.
REQ-012 The block SHALL have port mem_addr_age, output, 8 bits: age-port address.
REQ-013 The block SHALL have port mem_write_age, output, 1 bit: age-port write strobe (high = write).
REQ-014 The block SHALL have port mem_write_data_age, output, DW bits: age-port write data.
REQ-015 The block SHALL have port age_busy, output, 1 bit: high while a sweep is in progress.
REQ-016 The block SHALL have port age_done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-017 The block SHALL have port aged_count, output, 9 bits: number of entries invalidated in the current or most recent sweep.

Function
REQ-018 The entry format SHALL be: bit 82 valid, bits [81:50] timestamp, bits [49:48] port, bits [47:0] MAC.
REQ-019 The FSM SHALL have the states IDLE, RD, CHK, WR and DONE.
REQ-020 In IDLE, age_start=1 SHALL set the index to 0, clear aged_count and move to RD; otherwise the FSM SHALL stay in IDLE.
REQ-021 In RD, mem_addr_age SHALL equal the index and mem_write_age SHALL be 0, and the next state SHALL be CHK.
REQ-022 In CHK, the entry SHALL be stale when valid=1 and (cur_time - timestamp) mod 2^32 > age_limit (strictly greater).
REQ-023 In CHK, a stale entry SHALL move the FSM to WR, unless the conflict flag is set or an add-port write to the index occurs in that same cycle.
REQ-024 In CHK, a non-stale or conflicted entry SHALL cause an advance (REQ-027).
REQ-025 The conflict flag SHALL be cleared on entering RD and set by any cycle in RD or CHK with mem_write_add=1 and mem_addr_add equal to the index.
REQ-026 In WR, mem_write_age SHALL be 1 and mem_write_data_age SHALL be the CHK-cycle read data with bit 82 cleared, all other bits unchanged; the write SHALL be suppressed (strobe 0, no count) if an add-port write to the same address occurs that cycle; otherwise aged_count SHALL increment; the FSM SHALL then advance.
REQ-027 On advance, if the index equals DD-1 the next state SHALL be DONE; otherwise the index SHALL increment and the next state SHALL be RD.
REQ-028 DONE SHALL last one cycle with age_done=1, and the next state SHALL be IDLE.
REQ-029 age_busy SHALL be 1 in RD, CHK and WR, and 0 in IDLE and DONE.
REQ-030 age_start outside IDLE SHALL be ignored.
REQ-031 age_stop=1 in RD, CHK or WR SHALL make the next state IDLE with no age_done; a WR-cycle write already being driven in that cycle SHALL still commit.
REQ-032 age_stop SHALL take priority over all other transitions.
REQ-033 Outside WR, mem_write_age SHALL be 0 and mem_write_data_age SHALL be all zero.
REQ-034 Outside RD, CHK and WR, mem_addr_age SHALL hold the index.
REQ-035 aged_count SHALL hold its value after DONE until the next accepted age_start.
REQ-036 Sweep latency with no stale entries SHALL be exactly 2*DD cycles from RD of index 0 to DONE, plus 1 cycle per committed write.

Reset
REQ-037 When p_reset=1 at a clock edge, the FSM SHALL go to IDLE, the index and aged_count SHALL go to 0, the conflict flag SHALL clear, and all outputs SHALL be 0.
REQ-038 Reset SHALL take priority over age_start and age_stop.
REQ-039 Reset mid-sweep SHALL abort with no write in the following cycle.

Verification
REQ-040 The bench SHALL cover: all entries invalid, age_start pulse -> busy for 512 cycles, one age_done pulse, aged_count=0, no writes.
REQ-041 The bench SHALL cover: entry 5 valid, ts=100, cur_time=1000, age_limit=500 -> one write at address 5 with bit 82=0 and other bits identical, aged_count=1, 513 busy cycles.
REQ-042 The bench SHALL cover boundaries: ts=500, cur_time=1000, age_limit=500 (diff equal) -> no write; ts=0xFFFFFF00, cur_time=0x00000010, age_limit=0x200 (wrapped diff 0x110) -> no write; same entry with age_limit=0x100 -> write.
REQ-043 The bench SHALL cover: a stale entry at address 7 with mem_write_add=1 and mem_addr_add=7 during its CHK cycle -> no age-port write, aged_count unchanged.
REQ-044 The bench SHALL cover: age_start re-pulsed mid-sweep -> ignored; age_stop in a WR cycle -> that write commits, IDLE next, no age_done.
REQ-045 The bench SHALL cover: p_reset asserted in the CHK state of a stale entry -> no write, all outputs 0 the next cycle, and a new age_start afterwards sweeps from index 0.

Source files
------------

// File: rtl/alut_age_sched.sv
// Address-table ageing sweeper: reads every entry, and any valid entry older than age_limit
// has its valid bit cleared, unless the add/lookup port is touching the same slot.
module alut_age_sched #(
  parameter int DW = 83,
  parameter int DD = 256
) (
  input  logic          pclk,
  input  logic          p_reset,
  input  logic          age_start,
  input  logic          age_stop,
  input  logic [31:0]   cur_time,
  input  logic [31:0]   age_limit,
  input  logic [7:0]    mem_addr_add,
  input  logic          mem_write_add,
  input  logic [DW-1:0] mem_read_data_age,
  output logic [7:0]    mem_addr_age,
  output logic          mem_write_age,
  output logic [DW-1:0] mem_write_data_age,
  output logic          age_busy,
  output logic          age_done,
  output logic [8:0]    aged_count,
  output logic [2:0]    age_state
);

  // Control semantics: age_start is a one-cycle request that is honoured only in IDLE.
  // age_stop aborts from RD/CHK/WR back to IDLE without age_done. A write already being
  // driven in WR still commits.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DW-1:0] VALID_MASK = {{(DW-1){1'b0}}, 1'b1} << 82;
  localparam logic [7:0]    LAST_IDX   = 8'(DD - 1);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_idx;
  logic [8:0]    r_count;
  logic          r_conflict;
  logic [DW-1:0] r_rdata;

  logic          w_add_hit;
  logic [31:0]   w_age;
  logic          w_stale;
  logic          w_last;
  logic          w_busy;
  logic          w_advance;
  logic          w_wr_commit;

  assign w_add_hit   = mem_write_add && (mem_addr_add == r_idx);
  assign w_age       = cur_time - mem_read_data_age[81:50];
  assign w_stale     = mem_read_data_age[82] && (w_age > age_limit);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_busy      = (r_state == S_RD) || (r_state == S_CHK) || (r_state == S_WR);
  assign w_wr_commit = (r_state == S_WR) && !w_add_hit;

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: if (age_start) w_next = S_RD;
      S_RD:   w_next = S_CHK;
      S_CHK: begin
        if (w_stale && !r_conflict && !w_add_hit) w_next = S_WR;
        else                                      w_advance = 1'b1;
      end
      S_WR:   w_advance = 1'b1;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_advance) w_next = w_last ? S_DONE : S_RD;
    if (age_stop && w_busy) w_next = S_IDLE;
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 8'd0;
      r_count    <= 9'd0;
      r_conflict <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && age_start) begin
        r_idx   <= 8'd0;
        r_count <= 9'd0;
      end else if (w_advance && !w_last && !age_stop) begin
        r_idx <= r_idx + 8'd1;
      end
      if (w_wr_commit) r_count <= r_count + 9'd1;
      // A fresh RD starts a new slot, so any earlier add-port hit no longer applies.
      if (w_next == S_RD)
        r_conflict <= 1'b0;
      else if ((r_state == S_RD || r_state == S_CHK) && w_add_hit)
        r_conflict <= 1'b1;
      if (r_state == S_CHK) r_rdata <= mem_read_data_age;
    end
  end

  assign mem_addr_age       = r_idx;
  assign mem_write_age      = w_wr_commit;
  assign mem_write_data_age = (r_state == S_WR) ? (r_rdata & ~VALID_MASK) : '0;
  assign age_busy           = w_busy;
  assign age_done           = (r_state == S_DONE);
  assign aged_count         = r_count;
  assign age_state          = r_state;

endmodule
